// File: rtl/ascon_stream_ctrl_pkg.sv
// Shared constants and controller state encoding for the Ascon streaming controller.
package ascon_stream_ctrl_pkg;

   localparam int unsigned CT_W  = 64;
   localparam int unsigned TAG_W = 128;

   typedef logic [2:0] type_ctrl_state;

   localparam type_ctrl_state StIdle    = 3'd0;
   localparam type_ctrl_state StWaitRdy = 3'd1;
   localparam type_ctrl_state StStart   = 3'd2;
   localparam type_ctrl_state StStream  = 3'd3;
   localparam type_ctrl_state StWaitTag = 3'd4;
   localparam type_ctrl_state StTagOut  = 3'd5;

endpackage

// File: rtl/ascon_ct_fifo.sv
// Synchronous FIFO buffering core ciphertext words; push and pop may coincide when full.
module ascon_ct_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [WIDTH-1:0]        wdata_i,
   output logic [WIDTH-1:0]        rdata_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && full_o && !pop_i));

endmodule

// File: rtl/ascon_stream_ctrl.sv
// Job sequencer in front of the Ascon AEAD core: starts the core, meters words into it
// with ciphertext credit, buffers ciphertext and holds the tag for downstream.
module ascon_stream_ctrl
   import ascon_stream_ctrl_pkg::*;
#(
   parameter int unsigned BLK_AD_AW = 10,
   parameter int unsigned BLK_PT_AW = 10,
   parameter int unsigned CT_DEPTH  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 job_valid_i,
   output logic                 job_ready_o,
   input  logic [127:0]         job_key_i,
   input  logic [127:0]         job_nonce_i,
   input  logic [BLK_AD_AW-1:0] job_ad_size_i,
   input  logic [BLK_PT_AW-1:0] job_pt_size_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [CT_W-1:0]      in_data_i,
   output logic                 ct_valid_o,
   input  logic                 ct_ready_i,
   output logic [CT_W-1:0]      ct_data_o,
   output logic                 tag_valid_o,
   input  logic                 tag_ready_i,
   output logic [TAG_W-1:0]     tag_o,
   output logic                 busy_o,
   output logic                 core_start_o,
   output logic [127:0]         core_key_o,
   output logic [127:0]         core_nonce_o,
   output logic [BLK_AD_AW-1:0] core_ad_size_o,
   output logic [BLK_PT_AW-1:0] core_pt_size_o,
   output logic                 core_data_valid_o,
   output logic [CT_W-1:0]      core_data_o,
   input  logic                 core_data_req_i,
   input  logic                 core_ready_i,
   input  logic                 core_done_i,
   input  logic                 core_ct_valid_i,
   input  logic [CT_W-1:0]      core_ct_i,
   input  logic                 core_tag_valid_i,
   input  logic [TAG_W-1:0]     core_tag_i
);

   localparam int unsigned CNT_W = ((BLK_AD_AW > BLK_PT_AW) ? BLK_AD_AW : BLK_PT_AW) + 1;
   localparam int unsigned FC_W  = $clog2(CT_DEPTH) + 1;

   type_ctrl_state     state_q, state_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]   pt_left_q;
   logic [FC_W-1:0]    inflight_q;
   logic               buf_valid_q;
   logic [CT_W-1:0]    buf_data_q;
   logic [TAG_W-1:0]   tag_q;
   logic [127:0]       key_q, nonce_q;
   logic [BLK_AD_AW-1:0] ad_size_q;
   logic [BLK_PT_AW-1:0] pt_size_q;

   logic [FC_W-1:0]    fifo_count;
   logic               fifo_full, fifo_empty;
   logic [CT_W-1:0]    fifo_rdata;
   logic [FC_W:0]      occupancy;
   logic               is_pt, credit_ok, xfer, ct_pop;

   // Remaining words include every PT word, so the head word is PT once cnt <= pt_size.
   assign is_pt     = (word_cnt_q <= pt_left_q);
   assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
   assign credit_ok = ~is_pt | (occupancy < (FC_W+1)'(CT_DEPTH));
   assign xfer      = (state_q == StStream) & core_data_req_i & buf_valid_q & credit_ok;

   // Refill only while more words are still owed, so no stray word lingers past the job.
   assign in_ready_o = (state_q == StStream) &
                       (~buf_valid_q | (xfer & (word_cnt_q != CNT_W'(1))));

   assign job_ready_o       = (state_q == StIdle);
   assign busy_o            = (state_q != StIdle);
   assign core_start_o      = (state_q == StStart);
   assign core_data_valid_o = xfer;
   assign core_data_o       = buf_data_q;
   assign core_key_o        = key_q;
   assign core_nonce_o      = nonce_q;
   assign core_ad_size_o    = ad_size_q;
   assign core_pt_size_o    = pt_size_q;
   assign ct_valid_o        = ~fifo_empty;
   assign ct_data_o         = ct_valid_o ? fifo_rdata : '0;
   assign ct_pop            = ct_valid_o & ct_ready_i;
   assign tag_valid_o       = (state_q == StTagOut) & fifo_empty;
   assign tag_o             = tag_q;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      case (state_q)
         StIdle: begin
            if (job_valid_i) begin
               state_d    = StWaitRdy;
               word_cnt_d = CNT_W'(job_ad_size_i) + CNT_W'(job_pt_size_i);
            end
         end
         StWaitRdy: if (core_ready_i) state_d = StStart;
         StStart:   state_d = (word_cnt_q == '0) ? StWaitTag : StStream;
         StStream: begin
            if (xfer) begin
               word_cnt_d = word_cnt_q - CNT_W'(1);
               if (word_cnt_q == CNT_W'(1)) state_d = StWaitTag;
            end
         end
         StWaitTag: if (core_tag_valid_i) state_d = StTagOut;
         StTagOut:  if (tag_ready_i & fifo_empty) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         word_cnt_q  <= '0;
         pt_left_q   <= '0;
         inflight_q  <= '0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
         tag_q       <= '0;
         key_q       <= '0;
         nonce_q     <= '0;
         ad_size_q   <= '0;
         pt_size_q   <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         if (job_valid_i & job_ready_o) begin
            key_q     <= job_key_i;
            nonce_q   <= job_nonce_i;
            ad_size_q <= job_ad_size_i;
            pt_size_q <= job_pt_size_i;
            pt_left_q <= CNT_W'(job_pt_size_i);
         end
         if (in_valid_i & in_ready_o) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= in_data_i;
         end else if (xfer) begin
            buf_valid_q <= 1'b0;
         end
         case ({xfer & is_pt, core_ct_valid_i})
            2'b10:   inflight_q <= inflight_q + FC_W'(1);
            2'b01:   inflight_q <= inflight_q - FC_W'(1);
            default: inflight_q <= inflight_q;
         endcase
         if ((state_q == StWaitTag) & core_tag_valid_i) tag_q <= core_tag_i;
      end
   end

   ascon_ct_fifo #(
      .DEPTH (CT_DEPTH),
      .WIDTH (CT_W)
   ) u_ct_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (core_ct_valid_i),
      .pop_i   (ct_pop),
      .wdata_i (core_ct_i),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_ascon_stream_ctrl.sv
// Directed bench for ascon_stream_ctrl with a behavioural Ascon core stand-in.
module tb_ascon_stream_ctrl;

   localparam logic [63:0] CT_MASK = 64'hF0F0_0000_5A5A_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         job_valid, job_ready;
   logic [127:0] job_key, job_nonce;
   logic [9:0]   job_ad, job_pt;
   logic         in_valid, in_ready;
   logic [63:0]  in_data;
   logic         ct_valid, ct_ready;
   logic [63:0]  ct_data;
   logic         tag_valid, tag_ready;
   logic [127:0] tag;
   logic         busy, core_start;
   logic [127:0] core_key, core_nonce;
   logic [9:0]   core_ad_size, core_pt_size;
   logic         core_data_valid;
   logic [63:0]  core_data;
   logic         core_data_req, core_ready, core_done, core_ct_valid, core_tag_valid;
   logic [63:0]  core_ct;
   logic [127:0] core_tag;

   ascon_stream_ctrl #(
      .BLK_AD_AW (10),
      .BLK_PT_AW (10),
      .CT_DEPTH  (4)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .job_valid_i       (job_valid),
      .job_ready_o       (job_ready),
      .job_key_i         (job_key),
      .job_nonce_i       (job_nonce),
      .job_ad_size_i     (job_ad),
      .job_pt_size_i     (job_pt),
      .in_valid_i        (in_valid),
      .in_ready_o        (in_ready),
      .in_data_i         (in_data),
      .ct_valid_o        (ct_valid),
      .ct_ready_i        (ct_ready),
      .ct_data_o         (ct_data),
      .tag_valid_o       (tag_valid),
      .tag_ready_i       (tag_ready),
      .tag_o             (tag),
      .busy_o            (busy),
      .core_start_o      (core_start),
      .core_key_o        (core_key),
      .core_nonce_o      (core_nonce),
      .core_ad_size_o    (core_ad_size),
      .core_pt_size_o    (core_pt_size),
      .core_data_valid_o (core_data_valid),
      .core_data_o       (core_data),
      .core_data_req_i   (core_data_req),
      .core_ready_i      (core_ready),
      .core_done_i       (core_done),
      .core_ct_valid_i   (core_ct_valid),
      .core_ct_i         (core_ct),
      .core_tag_valid_i  (core_tag_valid),
      .core_tag_i        (core_tag)
   );

   // Stand-alone depth-2 FIFO for the full push+pop corner.
   logic        f_push, f_pop, f_full, f_empty;
   logic [63:0] f_wdata, f_rdata;
   logic [1:0]  f_count;

   ascon_ct_fifo #(
      .DEPTH (2),
      .WIDTH (64)
   ) u_fifo2 (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (f_push),
      .pop_i   (f_pop),
      .wdata_i (f_wdata),
      .rdata_o (f_rdata),
      .full_o  (f_full),
      .empty_o (f_empty),
      .count_o (f_count)
   );

   // Core stand-in: ct = pt ^ CT_MASK two cycles after transfer, tag = key ^ nonce ^ words.
   logic         m_busy, p0_v, p1_v, m_tag_v;
   logic [63:0]  p0_d, p1_d;
   logic [127:0] m_tag;
   int           m_total, m_ad, m_seen, m_tcnt;

   assign core_ready     = ~m_busy;
   assign core_data_req  = m_busy && (m_seen < m_total);
   assign core_ct_valid  = p1_v;
   assign core_ct        = p1_d;
   assign core_tag_valid = m_tag_v;
   assign core_tag       = m_tag;
   assign core_done      = m_tag_v;

   always @(posedge clk) begin
      p0_v    <= 1'b0;
      p1_v    <= p0_v;
      p1_d    <= p0_d;
      m_tag_v <= 1'b0;
      if (rst) begin
         m_busy  <= 1'b0;
         m_seen  <= 0;
         m_total <= 0;
         m_ad    <= 0;
         m_tcnt  <= 0;
         p1_v    <= 1'b0;
      end else if (core_start) begin
         m_busy  <= 1'b1;
         m_total <= int'(core_ad_size) + int'(core_pt_size);
         m_ad    <= int'(core_ad_size);
         m_seen  <= 0;
         m_tcnt  <= 0;
      end else if (m_busy) begin
         if (core_data_valid && core_data_req) begin
            m_seen <= m_seen + 1;
            if (m_seen >= m_ad) begin
               p0_v <= 1'b1;
               p0_d <= core_data ^ CT_MASK;
            end
         end else if (m_seen == m_total && !p0_v && !p1_v) begin
            if (m_tcnt == 3) begin
               m_tag_v <= 1'b1;
               m_tag   <= core_key ^ core_nonce ^ 128'(m_total);
               m_busy  <= 1'b0;
            end else begin
               m_tcnt <= m_tcnt + 1;
            end
         end
      end
   end

   logic [63:0] xfer_log[$];
   logic [63:0] ct_log[$];
   int          start_cnt = 0;
   int          occ = 0;
   int          max_occ = 0;

   always @(posedge clk) begin
      if (core_data_valid) xfer_log.push_back(core_data);
      if (ct_valid && ct_ready) ct_log.push_back(ct_data);
      if (core_start) start_cnt <= start_cnt + 1;
      if (rst) occ <= 0;
      else occ <= occ + (core_ct_valid ? 1 : 0) - ((ct_valid && ct_ready) ? 1 : 0);
      if (occ > max_occ) max_occ <= occ;
   end

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [127:0] key_of(input int id);
      return {64'h0123_4567_89AB_CDEF, 32'hCAFE_0000, 32'(id)};
   endfunction

   function automatic logic [127:0] nonce_of(input int id);
      return {32'(id), 96'hFEED_FACE_0000_1111_2222_3333};
   endfunction

   function automatic logic [63:0] word_of(input int id, input int i);
      return {16'hDA7A, 8'(id), 8'h00, 32'(i)};
   endfunction

   task automatic submit(input int id, input int ad, input int pt);
      int n = 0;
      @(negedge clk);
      job_valid = 1'b1;
      job_key   = key_of(id);
      job_nonce = nonce_of(id);
      job_ad    = 10'(ad);
      job_pt    = 10'(pt);
      #1;
      while (!job_ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check_eq("job_accept", 128'(job_ready), 128'd1);
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic feed(input int id, input int n_words);
      for (int i = 0; i < n_words; i++) begin
         int n = 0;
         in_valid = 1'b1;
         in_data  = word_of(id, i);
         #1;
         while (!in_ready && n < 200) begin
            @(negedge clk); #1; n++;
         end
         check_eq("in_ready", 128'(in_ready), 128'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic take_tag(input int id, input int total, input int pt, input int cb,
                           input int hold);
      int n = 0;
      logic [127:0] exp_tag;
      exp_tag = key_of(id) ^ nonce_of(id) ^ 128'(total);
      #1;
      while (!tag_valid && n < 300) begin
         @(negedge clk); #1; n++;
      end
      check_eq("tag_valid", 128'(tag_valid), 128'd1);
      check_eq("tag_value", tag, exp_tag);
      check_eq("ct_before_tag", 128'(ct_log.size() - cb), 128'(pt));
      if (hold > 0) begin
         job_valid = 1'b1;
         job_key   = key_of(99);
         job_nonce = nonce_of(99);
         job_ad    = 10'd1;
         job_pt    = 10'd1;
      end
      for (int c = 0; c < hold; c++) begin
         @(negedge clk); #1;
         check_eq("tag_hold_valid", 128'(tag_valid), 128'd1);
         check_eq("tag_hold_value", tag, exp_tag);
         check_eq("tag_hold_no_job", 128'(job_ready), 128'd0);
      end
      job_valid = 1'b0;
      tag_ready = 1'b1;
      @(negedge clk);
      tag_ready = 1'b0;
      #1;
      check_eq("tag_done_valid", 128'(tag_valid), 128'd0);
      check_eq("tag_done_busy", 128'(busy), 128'd0);
      check_eq("tag_done_job_ready", 128'(job_ready), 128'd1);
   endtask

   task automatic check_job(input int id, input int ad, input int pt, input int xb,
                            input int cb, input int sb);
      logic [63:0] v;
      check_eq("xfer_count", 128'(xfer_log.size() - xb), 128'(ad + pt));
      for (int i = 0; i < ad + pt; i++) begin
         v = (xb + i < xfer_log.size()) ? xfer_log[xb + i] : 64'h0;
         check_eq($sformatf("xfer[%0d]", i), 128'(v), 128'(word_of(id, i)));
      end
      check_eq("ct_count", 128'(ct_log.size() - cb), 128'(pt));
      for (int i = 0; i < pt; i++) begin
         v = (cb + i < ct_log.size()) ? ct_log[cb + i] : 64'h0;
         check_eq($sformatf("ct[%0d]", i), 128'(v), 128'(word_of(id, ad + i) ^ CT_MASK));
      end
      check_eq("start_pulses", 128'(start_cnt - sb), 128'd1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_job_ready"}, 128'(job_ready), 128'd1);
      check_eq({pfx, "_busy"}, 128'(busy), 128'd0);
      check_eq({pfx, "_in_ready"}, 128'(in_ready), 128'd0);
      check_eq({pfx, "_ct_valid"}, 128'(ct_valid), 128'd0);
      check_eq({pfx, "_ct_data"}, 128'(ct_data), 128'd0);
      check_eq({pfx, "_tag_valid"}, 128'(tag_valid), 128'd0);
      check_eq({pfx, "_tag"}, tag, 128'd0);
      check_eq({pfx, "_core_start"}, 128'(core_start), 128'd0);
      check_eq({pfx, "_core_data_valid"}, 128'(core_data_valid), 128'd0);
      check_eq({pfx, "_core_key"}, core_key, 128'd0);
      check_eq({pfx, "_core_ad_size"}, 128'(core_ad_size), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int xb, cb, sb;
      rst = 1'b1; job_valid = 1'b0; job_key = '0; job_nonce = '0; job_ad = '0; job_pt = '0;
      in_valid = 1'b0; in_data = '0; ct_ready = 1'b1; tag_ready = 1'b0;
      f_push = 1'b0; f_pop = 1'b0; f_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst");

      // ad=2 pt=3, downstream always ready
      xb = xfer_log.size(); cb = ct_log.size(); sb = start_cnt;
      submit(1, 2, 3);
      feed(1, 5);
      take_tag(1, 5, 3, cb, 0);
      check_job(1, 2, 3, xb, cb, sb);

      // empty job
      xb = xfer_log.size(); cb = ct_log.size(); sb = start_cnt;
      submit(2, 0, 0);
      take_tag(2, 0, 0, cb, 0);
      check_job(2, 0, 0, xb, cb, sb);

      // pt=8 with ct_ready low: credit must stall after CT_DEPTH PT words
      xb = xfer_log.size(); cb = ct_log.size(); sb = start_cnt;
      ct_ready = 1'b0;
      submit(3, 0, 8);
      fork
         feed(3, 8);
         begin
            repeat (40) @(negedge clk);
            #1;
            check_eq("stall_xfers", 128'(xfer_log.size() - xb), 128'd4);
            check_eq("stall_ct_valid", 128'(ct_valid), 128'd1);
            ct_ready = 1'b1;
         end
      join
      @(negedge clk);
      take_tag(3, 8, 8, cb, 0);
      check_job(3, 0, 8, xb, cb, sb);
      check_eq("max_fifo_occ_ok", 128'(max_occ <= 4), 128'd1);

      // tag withheld until FIFO drains, then held 10 cycles against tag_ready low
      xb = xfer_log.size(); cb = ct_log.size(); sb = start_cnt;
      ct_ready = 1'b0;
      submit(4, 0, 2);
      feed(4, 2);
      repeat (20) @(negedge clk);
      #1;
      check_eq("tag_gated_by_ct", 128'(tag_valid), 128'd0);
      check_eq("ct_pending", 128'(ct_valid), 128'd1);
      check_eq("busy_pending", 128'(busy), 128'd1);
      ct_ready = 1'b1;
      @(negedge clk);
      take_tag(4, 2, 2, cb, 10);
      check_job(4, 0, 2, xb, cb, sb);

      // reset mid-stream, then a short job
      submit(5, 2, 4);
      feed(5, 3);
      check_eq("midjob_busy", 128'(busy), 128'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      xb = xfer_log.size(); cb = ct_log.size(); sb = start_cnt;
      submit(6, 1, 1);
      feed(6, 2);
      take_tag(6, 2, 1, cb, 0);
      check_job(6, 1, 1, xb, cb, sb);

      // depth-2 FIFO: push/pop together while full
      @(negedge clk);
      f_push = 1'b1; f_wdata = 64'hAAAA_0000_0000_0001;
      @(negedge clk);
      f_wdata = 64'hBBBB_0000_0000_0002;
      @(negedge clk);
      #1;
      check_eq("f2_full", 128'(f_full), 128'd1);
      check_eq("f2_count_full", 128'(f_count), 128'd2);
      check_eq("f2_head_a", 128'(f_rdata), 128'h0000_0000_0000_0000_AAAA_0000_0000_0001);
      f_pop = 1'b1; f_wdata = 64'hCCCC_0000_0000_0003;
      @(negedge clk);
      f_push = 1'b0; f_pop = 1'b0;
      #1;
      check_eq("f2_count_pushpop", 128'(f_count), 128'd2);
      check_eq("f2_head_b", 128'(f_rdata), 128'h0000_0000_0000_0000_BBBB_0000_0000_0002);
      f_pop = 1'b1;
      @(negedge clk);
      #1;
      check_eq("f2_head_c", 128'(f_rdata), 128'h0000_0000_0000_0000_CCCC_0000_0000_0003);
      check_eq("f2_count_one", 128'(f_count), 128'd1);
      @(negedge clk);
      f_pop = 1'b0;
      #1;
      check_eq("f2_empty", 128'(f_empty), 128'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
